// File: rtl/pulse_pkg.sv
// Shared types and default widths for the pulse train generator.
package pulse_pkg;

    localparam int unsigned LEN_W_DEF = 8;
    localparam int unsigned CNT_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HIGH   = 2'd1,
        ST_LOW    = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/pulse_phase_timer.sv
// Phase down-counter: load starts a phase of max(length,1) cycles; expire
// is high in the final cycle of that phase.
module pulse_phase_timer
    import pulse_pkg::*;
#(
    parameter int unsigned LEN_W = LEN_W_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [LEN_W-1:0] length,
    output logic             expire
);

    logic [LEN_W-1:0] cnt;

    // Load length-1 (zero length counts as one cycle), then count down to zero and hold.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= (length == '0) ? '0 : length - LEN_W'(1);
        end else if (cnt != '0) begin
            cnt <= cnt - LEN_W'(1);
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Pulse train generator: count pulses of high_len high / low_len low cycles,
// then a one-cycle done strobe. Optional auto-repeat of the latched train is
// enabled by defining PULSE_TRAIN_REPEAT_EN (adds input repeat_en).
module pulse_train_gen
    import pulse_pkg::*;
#(
    parameter int unsigned LEN_W = LEN_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [LEN_W-1:0] high_len,
    input  logic [LEN_W-1:0] low_len,
    input  logic [CNT_W-1:0] count,
`ifdef PULSE_TRAIN_REPEAT_EN
    input  logic             repeat_en,
`endif
    output logic             signal,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pulse_idx
);

    state_t           state;
    logic [LEN_W-1:0] high_q;
    logic [LEN_W-1:0] low_q;
    logic [CNT_W-1:0] count_q;
    logic             last_pulse;
    logic             restart;
    logic             timer_load;
    logic [LEN_W-1:0] timer_len;
    logic             expire;

`ifdef PULSE_TRAIN_REPEAT_EN
    logic             rpt_q;
    assign restart = rpt_q;
`else
    assign restart = 1'b0;
`endif

    // Timer load strobe and phase length for the phase that begins on the next edge.
    always_comb begin
        last_pulse = (pulse_idx == count_q - CNT_W'(1));
        timer_load = 1'b0;
        timer_len  = high_q;
        unique case (state)
            ST_IDLE: begin
                timer_load = start && (count != '0);
                timer_len  = high_len;
            end
            ST_HIGH: begin
                timer_load = expire;
                timer_len  = low_q;
            end
            ST_LOW: begin
                timer_load = expire && !last_pulse;
                timer_len  = high_q;
            end
            ST_FINISH: begin
                timer_load = restart;
                timer_len  = high_q;
            end
            default: ;
        endcase
    end

    pulse_phase_timer #(
        .LEN_W (LEN_W)
    ) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (timer_load),
        .length  (timer_len),
        .expire  (expire)
    );

    // Train sequencer with registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            high_q    <= '0;
            low_q     <= '0;
            count_q   <= '0;
            signal    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pulse_idx <= '0;
`ifdef PULSE_TRAIN_REPEAT_EN
            rpt_q     <= 1'b0;
`endif
        end else begin
            unique case (state)
                ST_IDLE: begin
                    signal    <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    pulse_idx <= '0;
`ifdef PULSE_TRAIN_REPEAT_EN
                    rpt_q     <= 1'b0;
`endif
                    if (start) begin
                        high_q  <= high_len;
                        low_q   <= low_len;
                        count_q <= count;
                        if (count == '0) begin
                            state <= ST_FINISH;
                            done  <= 1'b1;
                        end else begin
                            state  <= ST_HIGH;
                            signal <= 1'b1;
                            busy   <= 1'b1;
                        end
                    end
                end
                ST_HIGH: begin
                    if (expire) begin
                        state  <= ST_LOW;
                        signal <= 1'b0;
                    end
                end
                ST_LOW: begin
                    if (expire) begin
                        if (last_pulse) begin
                            state <= ST_FINISH;
                            busy  <= 1'b0;
                            done  <= 1'b1;
`ifdef PULSE_TRAIN_REPEAT_EN
                            rpt_q <= repeat_en;
`endif
                        end else begin
                            state     <= ST_HIGH;
                            signal    <= 1'b1;
                            pulse_idx <= pulse_idx + CNT_W'(1);
                        end
                    end
                end
                ST_FINISH: begin
                    done      <= 1'b0;
                    pulse_idx <= '0;
                    if (restart) begin
                        state  <= ST_HIGH;
                        signal <= 1'b1;
                        busy   <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Self-checking bench for pulse_train_gen; covers the repeat feature when
// PULSE_TRAIN_REPEAT_EN is defined.
module tb_pulse_train_gen;

    localparam int unsigned LEN_W = 8;
    localparam int unsigned CNT_W = 4;

    logic             clock;
    logic             reset_n;
    logic             start;
    logic [LEN_W-1:0] high_len;
    logic [LEN_W-1:0] low_len;
    logic [CNT_W-1:0] count;
`ifdef PULSE_TRAIN_REPEAT_EN
    logic             repeat_en;
`endif
    logic             signal;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pulse_idx;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected per-cycle {signal,busy,done} and pulse index (-1 = not checked).
    logic [2:0] exp_q[$];
    int         idx_q[$];

    pulse_train_gen #(
        .LEN_W (LEN_W),
        .CNT_W (CNT_W)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .high_len  (high_len),
        .low_len   (low_len),
        .count     (count),
`ifdef PULSE_TRAIN_REPEAT_EN
        .repeat_en (repeat_en),
`endif
        .signal    (signal),
        .busy      (busy),
        .done      (done),
        .pulse_idx (pulse_idx)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: cycle list of one train starting the cycle after start.
    task automatic build_train(input int h, input int l, input int c, input bit with_idle);
        int he = (h == 0) ? 1 : h;
        int le = (l == 0) ? 1 : l;
        for (int p = 0; p < c; p++) begin
            for (int i = 0; i < he; i++) begin exp_q.push_back(3'b110); idx_q.push_back(p); end
            for (int i = 0; i < le; i++) begin exp_q.push_back(3'b010); idx_q.push_back(p); end
        end
        exp_q.push_back(3'b001); idx_q.push_back(-1);
        if (with_idle) begin
            for (int i = 0; i < 2; i++) begin exp_q.push_back(3'b000); idx_q.push_back(0); end
        end
    endtask

    task automatic drive_start(input int h, input int l, input int c);
        @(negedge clock);
        high_len = LEN_W'(h);
        low_len  = LEN_W'(l);
        count    = CNT_W'(c);
        start    = 1'b1;
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        #3;
        n_cmp++;
        if ({signal, busy, done, pulse_idx} !== '0) begin
            n_bad++;
            $display("FAIL reset_async: got %b%b%b idx=%0d, required 000 idx=0", signal, busy, done, pulse_idx);
        end
        @(posedge clock); #1;
        n_cmp++;
        if ({signal, busy, done, pulse_idx} !== '0) begin
            n_bad++;
            $display("FAIL reset_held: got %b%b%b idx=%0d, required 000 idx=0", signal, busy, done, pulse_idx);
        end
        @(negedge clock) reset_n = 1'b1;
    endtask

    task automatic test_case1();
        drive_start(4, 4, 3);
        for (int k = 1; k <= 27; k++) begin
            logic [2:0] e;
            int ei;
            @(negedge clock);
            if (k == 1) start = 1'b0;
            e[2] = (k >= 1 && k <= 4) || (k >= 9 && k <= 12) || (k >= 17 && k <= 20);
            e[1] = (k >= 1 && k <= 24);
            e[0] = (k == 25);
            ei = (k <= 8) ? 0 : (k <= 16) ? 1 : (k <= 24) ? 2 : (k == 25) ? -1 : 0;
            n_cmp++;
            if ({signal, busy, done} !== e || (ei >= 0 && pulse_idx !== CNT_W'(ei))) begin
                n_bad++;
                $display("FAIL case1 cycle %0d: got %b%b%b idx=%0d, required %b idx=%0d", k, signal, busy, done, pulse_idx, e, ei);
            end
        end
    endtask

    task automatic test_count_zero();
        drive_start(5, 5, 0);
        for (int k = 1; k <= 3; k++) begin
            logic [2:0] e;
            @(negedge clock);
            if (k == 1) start = 1'b0;
            e = (k == 1) ? 3'b001 : 3'b000;
            n_cmp++;
            if ({signal, busy, done} !== e || pulse_idx !== '0) begin
                n_bad++;
                $display("FAIL count_zero cycle %0d: got %b%b%b idx=%0d, required %b idx=0", k, signal, busy, done, pulse_idx, e);
            end
        end
    endtask

    task automatic test_zero_len();
        exp_q.delete(); idx_q.delete();
        build_train(0, 2, 2, 1);
        drive_start(0, 2, 2);
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clock);
            if (k == 0) start = 1'b0;
            n_cmp++;
            if ({signal, busy, done} !== exp_q[k] || (idx_q[k] >= 0 && pulse_idx !== CNT_W'(idx_q[k]))) begin
                n_bad++;
                $display("FAIL zero_len cycle %0d: got %b%b%b idx=%0d, required %b idx=%0d", k + 1, signal, busy, done, pulse_idx, exp_q[k], idx_q[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        drive_start(4, 4, 3);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            if (k == 1) start = 1'b0;
        end
        n_cmp++;
        if ({signal, busy, done} !== 3'b010) begin
            n_bad++;
            $display("FAIL reset_mid_pre: got %b%b%b, required 010", signal, busy, done);
        end
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({signal, busy, done, pulse_idx} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_async: got %b%b%b idx=%0d, required 000 idx=0", signal, busy, done, pulse_idx);
        end
        @(negedge clock);
        @(negedge clock) reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            n_cmp++;
            if ({signal, busy, done} !== 3'b000) begin
                n_bad++;
                $display("FAIL reset_mid_after %0d: got %b%b%b, required 000", k, signal, busy, done);
            end
        end
        exp_q.delete(); idx_q.delete();
        build_train(2, 1, 2, 1);
        drive_start(2, 1, 2);
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clock);
            if (k == 0) start = 1'b0;
            n_cmp++;
            if ({signal, busy, done} !== exp_q[k] || (idx_q[k] >= 0 && pulse_idx !== CNT_W'(idx_q[k]))) begin
                n_bad++;
                $display("FAIL reset_mid_restart cycle %0d: got %b%b%b idx=%0d, required %b idx=%0d", k + 1, signal, busy, done, pulse_idx, exp_q[k], idx_q[k]);
            end
        end
    endtask

    task automatic test_busy_ignore();
        exp_q.delete(); idx_q.delete();
        build_train(3, 2, 3, 1);
        drive_start(3, 2, 3);
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clock);
            n_cmp++;
            if ({signal, busy, done} !== exp_q[k] || (idx_q[k] >= 0 && pulse_idx !== CNT_W'(idx_q[k]))) begin
                n_bad++;
                $display("FAIL busy_ignore cycle %0d: got %b%b%b idx=%0d, required %b idx=%0d", k + 1, signal, busy, done, pulse_idx, exp_q[k], idx_q[k]);
            end
            if (exp_q[k][0] || exp_q[k] == 3'b000) begin
                start = 1'b0;
            end else begin
                start    = 1'b1;
                high_len = LEN_W'($urandom_range(0, 9));
                low_len  = LEN_W'($urandom_range(0, 9));
                count    = CNT_W'($urandom_range(0, 7));
            end
        end
    endtask

    task automatic test_max_len();
        exp_q.delete(); idx_q.delete();
        build_train(255, 255, 1, 1);
        drive_start(255, 255, 1);
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clock);
            if (k == 0) start = 1'b0;
            n_cmp++;
            if ({signal, busy, done} !== exp_q[k] || (idx_q[k] >= 0 && pulse_idx !== CNT_W'(idx_q[k]))) begin
                n_bad++;
                $display("FAIL max_len cycle %0d: got %b%b%b idx=%0d, required %b idx=%0d", k + 1, signal, busy, done, pulse_idx, exp_q[k], idx_q[k]);
            end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 12; t++) begin
            int h = $urandom_range(0, 6);
            int l = $urandom_range(0, 6);
            int c = $urandom_range(0, 5);
            exp_q.delete(); idx_q.delete();
            build_train(h, l, c, 1);
            drive_start(h, l, c);
            for (int k = 0; k < exp_q.size(); k++) begin
                @(negedge clock);
                if (k == 0) start = 1'b0;
                n_cmp++;
                if ({signal, busy, done} !== exp_q[k] || (idx_q[k] >= 0 && pulse_idx !== CNT_W'(idx_q[k]))) begin
                    n_bad++;
                    $display("FAIL random t%0d h=%0d l=%0d c=%0d cycle %0d: got %b%b%b idx=%0d, required %b idx=%0d",
                             t, h, l, c, k + 1, signal, busy, done, pulse_idx, exp_q[k], idx_q[k]);
                end
            end
        end
    endtask

`ifdef PULSE_TRAIN_REPEAT_EN
    task automatic test_repeat();
        int h = $urandom_range(1, 4);
        int l = $urandom_range(0, 3);
        int third;
        exp_q.delete(); idx_q.delete();
        for (int t = 0; t < 3; t++) begin
            if (t == 2) third = exp_q.size();
            build_train(h, l, 2, (t == 2));
        end
        repeat_en = 1'b1;
        drive_start(h, l, 2);
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clock);
            if (k == 0) start = 1'b0;
            if (k == third) repeat_en = 1'b0;
            n_cmp++;
            if ({signal, busy, done} !== exp_q[k] || (idx_q[k] >= 0 && pulse_idx !== CNT_W'(idx_q[k]))) begin
                n_bad++;
                $display("FAIL repeat cycle %0d: got %b%b%b idx=%0d, required %b idx=%0d", k + 1, signal, busy, done, pulse_idx, exp_q[k], idx_q[k]);
            end
        end
    endtask
`endif

    initial begin
        reset_n  = 1'b1;
        start    = 1'b0;
        high_len = '0;
        low_len  = '0;
        count    = '0;
`ifdef PULSE_TRAIN_REPEAT_EN
        repeat_en = 1'b0;
`endif
        test_reset();
        test_case1();
        test_count_zero();
        test_zero_len();
        test_reset_mid();
        test_busy_ignore();
        test_max_len();
        test_random();
`ifdef PULSE_TRAIN_REPEAT_EN
        test_repeat();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pulse_train_gen.md
PULSE_TRAIN_GEN -- requirements
Module: pulse_train_gen

Interface
REQ-001 SHALL have parameter LEN_W, default 8, meaning width of the high and low phase-length inputs.
REQ-002 SHALL have parameter CNT_W, default 4, meaning width of the pulse-count input and index output.
REQ-003 SHALL have port clock, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, train request, sampled only while idle.
REQ-006 SHALL have port high_len, input, LEN_W, high-phase length in clock cycles.
REQ-007 SHALL have port low_len, input, LEN_W, low-phase length in clock cycles.
REQ-008 SHALL have port count, input, CNT_W, number of pulses per train.
REQ-009 SHALL have port signal, output, 1, generated pulse train, registered.
REQ-010 SHALL have port busy, output, 1, high while a train is in progress.
REQ-011 SHALL have port done, output, 1, single-cycle completion strobe.
REQ-012 SHALL have port pulse_idx, output, CNT_W, zero-based index of the current pulse.

Function
REQ-013 SHALL implement the state machine IDLE -> HIGH -> LOW -> (HIGH | FINISH) -> IDLE.
REQ-014 In IDLE, start=1 at an edge SHALL latch high_len, low_len and count; later input changes SHALL be ignored until the next IDLE.
REQ-015 After a start edge with count>0, signal SHALL be 1 for exactly high_len cycles, then 0 for exactly low_len cycles, for each pulse.
REQ-016 A latched high_len or low_len of 0 SHALL be treated as 1 cycle.
REQ-017 The low phase of the last pulse SHALL be executed in full before FINISH.
REQ-018 In FINISH, done SHALL be 1 for exactly one cycle, busy SHALL be 0 in that cycle, and the state SHALL then return to IDLE.
REQ-019 A start with count=0 SHALL produce no high cycles and SHALL assert done on the edge after start.
REQ-020 busy SHALL be 1 from the edge after start through the last low cycle.
REQ-021 start asserted while busy or in FINISH SHALL be ignored, not queued.
REQ-022 pulse_idx SHALL increment at each LOW->HIGH transition and SHALL hold 0 in IDLE.
REQ-023 Phase counters SHALL be LEN_W bits wide and SHALL never wrap; maximum values of high_len and low_len SHALL yield 2^LEN_W-1 cycles.

Reset
REQ-024 reset_n=0 SHALL immediately force IDLE, with signal=0, busy=0, done=0 and pulse_idx=0, regardless of the clock.
REQ-025 Reset asserted mid-train SHALL abort the train without asserting done; after release, a new start SHALL be required.

Configuration
REQ-026 With PULSE_TRAIN_REPEAT_EN defined, the module SHALL have an input port repeat (1 bit); if repeat=1 when the last low phase ends, done SHALL still pulse, and the next train SHALL begin one cycle after done using the latched values, with busy returning to 1.
REQ-027 A repeating train SHALL stop at the end of the current train once repeat=0.
REQ-028 Without PULSE_TRAIN_REPEAT_EN, the repeat port and its logic SHALL be absent, and behaviour SHALL be exactly REQ-013 through REQ-025.

Structure
REQ-029 Package pulse_pkg SHALL hold the state enumeration typedef and the default LEN_W and CNT_W constants.
REQ-030 The phase down-counter SHALL be the sub-module pulse_phase_timer, with load, length and expire ports, instantiated once.

Verification
REQ-031 Case 1: high_len=4, low_len=4, count=3, start pulse -> signal=1 for cycles 1-4, 9-12 and 17-20; busy=1 for cycles 1-24; done=1 at cycle 25 only.
REQ-032 Case 2: count=0, start pulse -> signal stays 0, busy stays 0, done=1 on the next edge.
REQ-033 Case 3: high_len=0, low_len=2, count=2 -> high, low, low, high, low, low, then done.
REQ-034 Case 4: reset_n pulled low at cycle 6 of Case 1 -> all outputs 0 asynchronously, no done; a new start after release restarts from pulse_idx=0.
REQ-035 Case 5: start re-asserted while busy, and high_len changed mid-train -> train unchanged and no second train.
REQ-036 Case 6 (PULSE_TRAIN_REPEAT_EN defined): repeat=1 with count=2 -> periodic done strobes and contiguous trains; repeat set to 0 -> current train completes, then IDLE.
